// File: rtl/nanov_pkg.sv
// Shared constants and types for the nanoV bit-serial register file.
package nanov_pkg;

   localparam int NANOV_NUM_REGS = 16;
   localparam int NANOV_XLEN     = 32;

   typedef logic [3:0] nanov_reg_idx_t;

endpackage

// File: rtl/nanov_serial_reg.sv
// One 32-bit rotating register: shifts right every cycle, with a current-bit and a next-bit write.
// Reset clearing of the contents is enabled by NANOV_REG_RESET_EN.
module nanov_serial_reg
   import nanov_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  logic wr_next_en,
   input  logic data,
   input  logic next_data,
   output logic cur_bit
);

   logic [NANOV_XLEN-1:0] bits;
   logic [NANOV_XLEN-1:0] rotated;

   // The next-bit write lands in bit 1 before the shift, so it is the LSB after the edge.
   always_comb begin
      rotated = {bits[0], bits[NANOV_XLEN-1:1]};
      if (wr_next_en) begin
         rotated[0] = next_data;
      end
      if (wr_en) begin
         rotated[NANOV_XLEN-1] = data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
`ifdef NANOV_REG_RESET_EN
         bits <= '0;
`else
         bits <= bits;
`endif
      end else begin
         bits <= rotated;
      end
   end

   assign cur_bit = bits[0];

endmodule

// File: rtl/nanov_regfile_serial.sv
// Bit-serial RV32E register file: x1..x15 rotate one bit per clock, x0 reads zero.
// Define NANOV_REG_RESET_EN to clear the register contents on reset.
module nanov_regfile_serial
   import nanov_pkg::*;
(
   input  logic           clk,
   input  logic           rstn,
   input  logic           wr_en,
   input  logic           wr_next_en,
   input  logic           read_through,
   input  nanov_reg_idx_t rs1,
   input  nanov_reg_idx_t rs2,
   input  nanov_reg_idx_t rd,
   output logic           data_rs1,
   output logic           data_rs2,
   input  logic           data_rd,
   input  logic           next_data_rd
);

   logic [NANOV_NUM_REGS-1:0] cur_bits;

   assign cur_bits[0] = 1'b0;

   for (genvar i = 1; i < NANOV_NUM_REGS; i++) begin : g_reg
      logic sel;
      assign sel = (rd == nanov_reg_idx_t'(i));

      nanov_serial_reg u_reg (
         .clk        (clk),
         .rst        (rstn),
         .wr_en      (wr_en && sel),
         .wr_next_en (wr_next_en && sel),
         .data       (data_rd),
         .next_data  (next_data_rd),
         .cur_bit    (cur_bits[i])
      );
   end

   // x0 needs no special case here: its slot is tied low and bypass requires rd != 0.
   always_comb begin
      data_rs1 = cur_bits[rs1];
      data_rs2 = cur_bits[rs2];
      if (read_through && wr_en && (rd != '0)) begin
         if (rs1 == rd) begin
            data_rs1 = data_rd;
         end
         if (rs2 == rd) begin
            data_rs2 = data_rd;
         end
      end
   end

endmodule

// File: tb/tb_nanov_regfile_serial.sv
// Randomized and directed self-checking bench for nanov_regfile_serial against an architectural word model.
module tb_nanov_regfile_serial;

   logic       clk = 1'b0;
   logic       rstn;
   logic       wr_en, wr_next_en, read_through;
   logic [3:0] rs1, rs2, rd;
   logic       data_rs1, data_rs2;
   logic       data_rd, next_data_rd;

   nanov_regfile_serial dut (
      .clk          (clk),
      .rstn         (rstn),
      .wr_en        (wr_en),
      .wr_next_en   (wr_next_en),
      .read_through (read_through),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .data_rs1     (data_rs1),
      .data_rs2     (data_rs2),
      .data_rd      (data_rd),
      .next_data_rd (next_data_rd)
   );

   always #5 clk = ~clk;

   // Architectural model: arch[i][b] is bit b of register i; known marks bits that were defined.
   logic [31:0] arch  [16];
   logic [31:0] known [16];
   int          mc;
   int          checks   = 0;
   int          failures = 0;
   logic        last1, last2;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (c=%0d, t=%0t)", tag, act, exp, mc, $time);
      end
   endtask

   function automatic logic expRead(input logic [3:0] r, input logic we, input logic rt,
                                    input logic [3:0] rdi, input logic d, output logic kn);
      kn = 1'b1;
      if (r == 4'd0) return 1'b0;
      if (rt && we && (rdi == r)) return d;
      kn = known[r][mc];
      return arch[r][mc];
   endfunction

   // Drives one cycle, checks both read ports against the model, then advances across the edge.
   task automatic applyStimulus(input logic we, input logic wne, input logic rt,
                                input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rdi,
                                input logic d, input logic nd);
      logic e1, e2, k1, k2;
      wr_en = we; wr_next_en = wne; read_through = rt;
      rs1 = r1; rs2 = r2; rd = rdi; data_rd = d; next_data_rd = nd;
      #1;
      e1 = expRead(r1, we, rt, rdi, d, k1);
      e2 = expRead(r2, we, rt, rdi, d, k2);
      if (k1) checkOutput("rs1_bit", {31'd0, data_rs1}, {31'd0, e1});
      if (k2) checkOutput("rs2_bit", {31'd0, data_rs2}, {31'd0, e2});
      last1 = data_rs1;
      last2 = data_rs2;
      @(posedge clk);
      if (we && rdi != 4'd0) begin
         arch[rdi][mc]  = d;
         known[rdi][mc] = 1'b1;
      end
      if (wne && rdi != 4'd0) begin
         arch[rdi][(mc + 1) % 32]  = nd;
         known[rdi][(mc + 1) % 32] = 1'b1;
      end
      mc = (mc + 1) % 32;
      #1;
   endtask

   // Reset: contents either clear or freeze, and the frame restarts so the old bit c becomes bit 0.
   task automatic doReset(input int n);
      logic [31:0] a, k;
      rstn = 1'b1;
      wr_en = 1'b0; wr_next_en = 1'b0; read_through = 1'b0;
      for (int i = 0; i < 16; i++) begin
`ifdef NANOV_REG_RESET_EN
         arch[i]  = '0;
         known[i] = '1;
`else
         a = arch[i];
         k = known[i];
         for (int j = 0; j < 32; j++) begin
            arch[i][j]  = a[(j + mc) % 32];
            known[i][j] = k[(j + mc) % 32];
         end
`endif
      end
      mc = 0;
      for (int i = 0; i < n; i++) begin
         rs1 = 4'd0;
         rs2 = 4'($urandom_range(1, 15));
         #1;
         checkOutput("rst_x0", {31'd0, data_rs1}, 32'd0);
         if (known[rs2][0]) checkOutput("rst_hold", {31'd0, data_rs2}, {31'd0, arch[rs2][0]});
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
   endtask

   task automatic runFrame(input logic we, input logic rt, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [3:0] rdi, input logic [31:0] val,
                           output logic [31:0] w1, output logic [31:0] w2);
      for (int b = 0; b < 32; b++) begin
         applyStimulus(we, 1'b0, rt, r1, r2, rdi, val[b], 1'b0);
         w1[b] = last1;
         w2[b] = last2;
      end
   endtask

   task automatic idleTo(input int target);
      int guard = 0;
      while (mc != target && guard < 64) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
         guard++;
      end
      if (mc != target) checkOutput("align", mc, target);
   endtask

   logic [31:0] w1, w2, pat;

   initial begin
      for (int i = 0; i < 16; i++) begin
         arch[i]  = '0;
         known[i] = '0;
      end
      mc = 0;
      rs1 = '0; rs2 = '0; rd = '0; data_rd = 1'b0; next_data_rd = 1'b0;
      #2;
      doReset(3);

      // Full-word write then read on both ports.
      runFrame(1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF, w1, w2);
      runFrame(1'b0, 1'b0, 4'd5, 4'd5, 4'd0, 32'h0, w1, w2);
      checkOutput("x5_rs1_word", w1, 32'hDEADBEEF);
      checkOutput("x5_rs2_word", w2, 32'hDEADBEEF);

      // x0 discards writes, even with bypass requested; x15 is independent.
      runFrame(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF, w1, w2);
      checkOutput("x0_bypass_word", w1, 32'h0);
      runFrame(1'b1, 1'b0, 4'd0, 4'd0, 4'd15, 32'h12345678, w1, w2);
      runFrame(1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h0, w1, w2);
      checkOutput("x0_word", w1, 32'h0);
      checkOutput("x15_word", w2, 32'h12345678);
`ifdef NANOV_REG_RESET_EN
      runFrame(1'b0, 1'b0, 4'd3, 4'd5, 4'd0, 32'h0, w1, w2);
      checkOutput("x3_untouched", w1, 32'h0);
      checkOutput("x5_retained", w2, 32'hDEADBEEF);
`endif

      // Bypass on, then off: with it off the old contents show during the write.
      runFrame(1'b1, 1'b1, 4'd7, 4'd0, 4'd7, 32'hA5A5A5A5, w1, w2);
      checkOutput("bypass_on", w1, 32'hA5A5A5A5);
      runFrame(1'b1, 1'b0, 4'd7, 4'd0, 4'd7, 32'h3C3C3C3C, w1, w2);
      checkOutput("bypass_off", w1, 32'hA5A5A5A5);
      runFrame(1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 32'h0, w1, w2);
      checkOutput("x7_after", w1, 32'h3C3C3C3C);

      // Next-bit write from c=31 through c=30 fills the following frame.
      pat = 32'h0F0F0F0F;
      idleTo(31);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, pat[(mc + 1) % 32]);
      end
      idleTo(0);
      runFrame(1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 32'h0, w1, w2);
      checkOutput("x2_next_word", w1, 32'h0F0F0F0F);

      // Reset in the middle of writing x4.
      pat = 32'hFFFFFFFF;
      for (int b = 0; b < 13; b++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, pat[b], 1'b0);
      end
      doReset(2);
`ifdef NANOV_REG_RESET_EN
      runFrame(1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 32'h0, w1, w2);
      checkOutput("x4_aborted", w1, 32'h0);
`endif
      runFrame(1'b1, 1'b0, 4'd0, 4'd0, 4'd4, 32'hCAFEF00D, w1, w2);
      runFrame(1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 32'h0, w1, w2);
      checkOutput("x4_rewrite", w1, 32'hCAFEF00D);
      checkOutput("x4_rewrite_rs2", w2, 32'hCAFEF00D);

      // Random traffic, with one reset at a random point in the middle.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            doReset(int'($urandom_range(1, 3)));
         end
         applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom), 4'($urandom), 4'($urandom),
                       1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
